// File: rtl/oam_dma.sv
// oam_dma: $4014 sprite DMA that halts the CPU and copies one 256-byte page into OAM through $2004.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA   = 16'h2004,
  parameter int          XFER_LEN  = 256
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr,
  input  logic        odd_or_even,
  input  logic [7:0]  mem_din,
  output logic        dma_hijack,
  output logic [15:0] dma_addr,
  output logic        dma_wr,
  output logic [7:0]  dma_dout,
  output logic        dma_done
);
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_n;
  logic [7:0] page, page_n, idx, idx_n;
  logic hijack_n, wr_n, done_n;
  logic [15:0] addr_n;
  always_comb begin
    state_n = state;
    page_n = page;
    idx_n = idx;
    case (state)
      IDLE: if (bus_addr == TRIG_ADDR && !bus_wr) begin
        state_n = HALT;
        page_n = bus_din;
        idx_n = '0;
      end
      HALT: state_n = odd_or_even ? ALIGN : READ;
      ALIGN: state_n = READ;
      READ: state_n = WRITE;
      WRITE: begin
        idx_n = (idx == LAST) ? '0 : idx + 8'd1;
        state_n = (idx == LAST) ? IDLE : READ;
      end
      default: state_n = IDLE;
    endcase
    hijack_n = state_n != IDLE;
    wr_n = state_n != WRITE;
    addr_n = (state_n == HALT || state_n == ALIGN) ? TRIG_ADDR :
             (state_n == READ) ? {page_n, idx_n} :
             (state_n == WRITE) ? OAMDATA : 16'h0000;
    done_n = state == WRITE && state_n == IDLE;
  end
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      page <= '0;
      idx <= '0;
      dma_hijack <= 1'b0;
      dma_addr <= '0;
      dma_wr <= 1'b1;
      dma_done <= 1'b0;
    end else begin
      state <= state_n;
      page <= page_n;
      idx <= idx_n;
      dma_hijack <= hijack_n;
      dma_addr <= addr_n;
      dma_wr <= wr_n;
      dma_done <= done_n;
    end
  end
  // Sync RAM returns the READ byte during the WRITE cycle, so the data is forwarded rather than registered.
  assign dma_dout = (state == WRITE) ? mem_din : 8'h00;
endmodule
